// File: rtl/resv_pkg.sv
// resv_pkg: shared reservation-station constants and the payload field layout.
package resv_pkg;
    localparam int W_ident = 4;
    localparam int N_cell = 8;
    localparam logic [W_ident-1:0] unused_cd = '1;
    localparam int W_uops = 16;
    localparam int W_data = 32;
    localparam logic [W_uops-1:0] unused_op = '1;
    localparam int off_pc = 0;
    localparam int off_imm = off_pc + W_data;
    localparam int off_rt = off_imm + W_data;
    localparam int off_rs = off_rt + W_data;
    localparam int off_uops = off_rs + W_data;
    localparam int W_pay = off_uops + W_uops;

    function automatic logic [W_pay-1:0] pack_payload(input logic [W_uops-1:0] uops,
                                                      input logic [W_data-1:0] rs, rt, imm, pc);
        logic [W_pay-1:0] p;
        p = '0;
        p[off_uops +: W_uops] = uops;
        p[off_rs +: W_data] = rs;
        p[off_rt +: W_data] = rt;
        p[off_imm +: W_data] = imm;
        p[off_pc +: W_data] = pc;
        return p;
    endfunction
endpackage

// File: rtl/resv_prio_enc.sv
// resv_prio_enc: lowest occupied cell whose code is not unused; lowest index is the oldest entry.
module resv_prio_enc #(
    parameter int W_ident = resv_pkg::W_ident,
    parameter int N_cell = resv_pkg::N_cell
) (
    input  logic [N_cell*W_ident-1:0] codes,
    input  logic [W_ident-1:0]        count,
    output logic [W_ident-1:0]        idx,
    output logic                      found
);
    always_comb begin
        idx = '1;
        found = 1'b0;
        for (int i = N_cell - 1; i >= 0; i--) begin
            if (W_ident'(i) < count && codes[i*W_ident +: W_ident] != '1) begin
                idx = W_ident'(i);
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/resv_issue_ctrl.sv
// resv_issue_ctrl: occupancy, insert and two-pipe issue control for one reservation station.
module resv_issue_ctrl #(
    parameter int W_ident = resv_pkg::W_ident,
    parameter int N_cell = resv_pkg::N_cell,
    parameter int W_pay = resv_pkg::W_pay
) (
    input  logic                      clk,
    input  logic                      clear_n,
    input  logic                      flush,
    input  logic [N_cell*W_ident-1:0] candit0_all,
    input  logic [N_cell*W_ident-1:0] candit1_all,
    input  logic                      ins_valid,
    output logic                      ins_ready,
    output logic [W_ident-1:0]        addr_insert,
    output logic [W_ident-1:0]        addr_shift,
    output logic                      cell_clear,
    output logic [W_ident-1:0]        sel_idx,
    input  logic [W_pay-1:0]          sel_payload,
    output logic                      iss0_valid,
    input  logic                      iss0_ready,
    output logic [W_pay-1:0]          iss0_payload,
    output logic                      iss1_valid,
    input  logic                      iss1_ready,
    output logic [W_pay-1:0]          iss1_payload,
    output logic [W_ident-1:0]        count,
    output logic                      full
);
    localparam logic [W_ident-1:0] unused_cd = '1;

    logic [W_ident-1:0] idx0, idx1;
    logic found0, found1, go0, go1, pick1, issue, ins_acc, rr;

    resv_prio_enc #(.W_ident(W_ident), .N_cell(N_cell)) u_enc0 (
        .codes(candit0_all), .count(count), .idx(idx0), .found(found0)
    );
    resv_prio_enc #(.W_ident(W_ident), .N_cell(N_cell)) u_enc1 (
        .codes(candit1_all), .count(count), .idx(idx1), .found(found1)
    );

    assign full = count == W_ident'(N_cell);
    assign go0 = found0 && (!iss0_valid || iss0_ready) && !flush;
    assign go1 = found1 && (!iss1_valid || iss1_ready) && !flush;
    assign pick1 = go1 && (!go0 || rr);
    assign issue = go0 || go1;
    assign sel_idx = issue ? (pick1 ? idx1 : idx0) : unused_cd;
    assign addr_shift = sel_idx;
    assign ins_ready = !flush && !cell_clear && (!full || issue);
    assign ins_acc = ins_valid && ins_ready;
    // while issuing, the tail shifts down one slot, so the new entry lands one below count
    assign addr_insert = ins_acc ? count - W_ident'(issue) : unused_cd;

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            count <= '0;
            rr <= 1'b0;
            iss0_valid <= 1'b0;
            iss1_valid <= 1'b0;
            iss0_payload <= '0;
            iss1_payload <= '0;
            cell_clear <= 1'b1;
        end else begin
            cell_clear <= flush;
            if (flush) begin
                count <= '0;
                iss0_valid <= 1'b0;
                iss1_valid <= 1'b0;
            end else begin
                count <= count + W_ident'(ins_acc) - W_ident'(issue);
                rr <= (go0 && go1) ? !rr : rr;
                iss0_valid <= (issue && !pick1) || (iss0_valid && !iss0_ready);
                iss1_valid <= pick1 || (iss1_valid && !iss1_ready);
                if (issue && !pick1)
                    iss0_payload <= sel_payload;
                if (pick1)
                    iss1_payload <= sel_payload;
            end
        end
    end
endmodule

// File: tb/tb_resv_issue_ctrl.sv
// tb_resv_issue_ctrl: directed vector table plus hand-written flush/async-reset sequences.
module tb_resv_issue_ctrl;
    import resv_pkg::*;

    localparam int N = 8;
    localparam int NV = 29;
    localparam logic [31:0] NC = 32'hFFFF_FFFF;

    typedef struct {
        logic fl, iv, r0, r1;
        logic [31:0] c0, c1;
        logic [3:0] sel, ai;
        logic rdy;
        logic [3:0] cnt;
        logic fu, cc, v0, v1;
        logic [3:0] p0, p1;
    } vec_t;

    logic clk = 0, clear_n = 0, flush = 0, ins_valid = 1, iss0_ready = 1, iss1_ready = 1;
    logic [N*W_ident-1:0] candit0_all = '1, candit1_all = '1;
    logic ins_ready, cell_clear, iss0_valid, iss1_valid, full;
    logic [W_ident-1:0] addr_insert, addr_shift, sel_idx, count;
    logic [W_pay-1:0] sel_payload, iss0_payload, iss1_payload;
    logic [W_pay-1:0] pay [N];
    vec_t v [NV];
    int errors = 0, checks = 0;

    resv_issue_ctrl dut (
        .clk(clk), .clear_n(clear_n), .flush(flush),
        .candit0_all(candit0_all), .candit1_all(candit1_all),
        .ins_valid(ins_valid), .ins_ready(ins_ready),
        .addr_insert(addr_insert), .addr_shift(addr_shift),
        .cell_clear(cell_clear), .sel_idx(sel_idx), .sel_payload(sel_payload),
        .iss0_valid(iss0_valid), .iss0_ready(iss0_ready), .iss0_payload(iss0_payload),
        .iss1_valid(iss1_valid), .iss1_ready(iss1_ready), .iss1_payload(iss1_payload),
        .count(count), .full(full)
    );

    always #5 clk = ~clk;

    // stands in for the cell array's payload mux
    always_comb sel_payload = (sel_idx < W_ident'(N)) ? pay[sel_idx[2:0]] : '0;

    task automatic chk(input string nm, input logic [W_pay-1:0] act, input logic [W_pay-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic fl, iv, r0, r1, input logic [31:0] c0, c1,
                                input logic [3:0] sel, ai, input logic rdy, input logic [3:0] cnt,
                                input logic fu, cc, v0, v1, input logic [3:0] p0, p1);
        vec_t r;
        r.fl = fl; r.iv = iv; r.r0 = r0; r.r1 = r1; r.c0 = c0; r.c1 = c1;
        r.sel = sel; r.ai = ai; r.rdy = rdy; r.cnt = cnt;
        r.fu = fu; r.cc = cc; r.v0 = v0; r.v1 = v1; r.p0 = p0; r.p1 = p1;
        return r;
    endfunction

    initial begin
        for (int i = 0; i < N; i++)
            pay[i] = pack_payload(16'(i + 1), 32'(i * 3 + 7), 32'(i << 8), 32'(32'hABC0 + i), 32'(32'h4000 + 4 * i));
        // fields: fl iv r0 r1 c0 c1 | sel ai rdy cnt full cc v0 v1 p0 p1
        v[0] = mk(0, 1, 1, 1, NC, NC, 4'hF, 4'hF, 0, 0, 0, 1, 0, 0, 4'hF, 4'hF);
        for (int k = 1; k <= 8; k++)
            v[k] = mk(0, 1, 1, 1, NC, NC, 4'hF, 4'(k - 1), 1, 4'(k - 1), 0, 0, 0, 0, 4'hF, 4'hF);
        v[9]  = mk(0, 1, 1, 1, NC, NC, 4'hF, 4'hF, 0, 8, 1, 0, 0, 0, 4'hF, 4'hF);
        v[10] = mk(0, 1, 1, 1, 32'hFFFF_F0FF, NC, 2, 7, 1, 8, 1, 0, 0, 0, 4'hF, 4'hF);
        v[11] = mk(0, 0, 0, 1, NC, NC, 4'hF, 4'hF, 0, 8, 1, 0, 1, 0, 2, 4'hF);
        v[12] = mk(1, 1, 0, 1, 32'hFFFF_FFF0, NC, 4'hF, 4'hF, 0, 8, 1, 0, 1, 0, 2, 4'hF);
        v[13] = mk(0, 1, 1, 1, NC, NC, 4'hF, 4'hF, 0, 0, 0, 1, 0, 0, 4'hF, 4'hF);
        for (int k = 0; k < 5; k++)
            v[14 + k] = mk(0, 1, 1, 1, NC, NC, 4'hF, 4'(k), 1, 4'(k), 0, 0, 0, 0, 4'hF, 4'hF);
        v[19] = mk(0, 0, 1, 1, 32'hF0FF_0F0F, NC, 1, 4'hF, 1, 5, 0, 0, 0, 0, 4'hF, 4'hF);
        v[20] = mk(0, 1, 1, 1, 32'hFFFF_FFF0, 32'hFFFF_F0FF, 0, 3, 1, 4, 0, 0, 1, 0, 1, 4'hF);
        v[21] = mk(0, 1, 1, 1, 32'hFFFF_FFF0, 32'hFFFF_F0FF, 2, 3, 1, 4, 0, 0, 1, 0, 0, 4'hF);
        v[22] = mk(0, 1, 1, 1, 32'hFFFF_FFF0, 32'hFFFF_F0FF, 0, 3, 1, 4, 0, 0, 0, 1, 4'hF, 2);
        v[23] = mk(0, 0, 1, 1, NC, 32'hFFFF_F0FF, 2, 4'hF, 1, 4, 0, 0, 1, 0, 0, 4'hF);
        v[24] = mk(0, 0, 1, 0, NC, 32'hFFFF_FF0F, 4'hF, 4'hF, 1, 3, 0, 0, 0, 1, 4'hF, 2);
        v[25] = mk(0, 0, 1, 1, NC, 32'hFFFF_FF0F, 1, 4'hF, 1, 3, 0, 0, 0, 1, 4'hF, 2);
        v[26] = mk(0, 0, 1, 1, NC, NC, 4'hF, 4'hF, 1, 2, 0, 0, 0, 1, 4'hF, 1);
        v[27] = mk(0, 0, 1, 1, 32'hFFFF_FFF0, 32'hFFFF_FF0F, 1, 4'hF, 1, 2, 0, 0, 0, 0, 4'hF, 4'hF);
        v[28] = mk(0, 0, 1, 1, NC, NC, 4'hF, 4'hF, 1, 1, 0, 0, 0, 1, 4'hF, 1);

        repeat (3) @(posedge clk);
        #1;
        chk("reset count", count, 0);
        chk("reset cell_clear", cell_clear, 1);
        chk("reset ins_ready", ins_ready, 0);
        chk("reset iss0_valid", iss0_valid, 0);
        chk("reset iss1_valid", iss1_valid, 0);
        chk("reset iss0_payload", iss0_payload, 0);
        chk("reset addr_insert", addr_insert, 4'hF);
        clear_n = 1;

        for (int i = 0; i < NV; i++) begin
            flush = v[i].fl; ins_valid = v[i].iv;
            iss0_ready = v[i].r0; iss1_ready = v[i].r1;
            candit0_all = v[i].c0; candit1_all = v[i].c1;
            #1;
            chk($sformatf("r%0d sel_idx", i), sel_idx, v[i].sel);
            chk($sformatf("r%0d addr_shift", i), addr_shift, v[i].sel);
            chk($sformatf("r%0d addr_insert", i), addr_insert, v[i].ai);
            chk($sformatf("r%0d ins_ready", i), ins_ready, v[i].rdy);
            chk($sformatf("r%0d count", i), count, v[i].cnt);
            chk($sformatf("r%0d full", i), full, v[i].fu);
            chk($sformatf("r%0d cell_clear", i), cell_clear, v[i].cc);
            chk($sformatf("r%0d iss0_valid", i), iss0_valid, v[i].v0);
            chk($sformatf("r%0d iss1_valid", i), iss1_valid, v[i].v1);
            if (v[i].p0 != 4'hF)
                chk($sformatf("r%0d iss0_payload", i), iss0_payload, pay[v[i].p0[2:0]]);
            if (v[i].p1 != 4'hF)
                chk($sformatf("r%0d iss1_payload", i), iss1_payload, pay[v[i].p1[2:0]]);
            @(posedge clk);
            #1;
        end

        // issue and insert together at count 1, then reset asynchronously mid-cycle
        candit0_all = 32'hFFFF_FFF0; candit1_all = NC; ins_valid = 1; iss0_ready = 1; flush = 0;
        #1;
        chk("ar sel_idx", sel_idx, 0);
        chk("ar addr_insert", addr_insert, 0);
        @(posedge clk);
        #1;
        candit0_all = NC; ins_valid = 0; iss0_ready = 0;
        chk("ar pre count", count, 1);
        chk("ar pre iss0_valid", iss0_valid, 1);
        chk("ar pre iss0_payload", iss0_payload, pay[0]);
        #2;
        clear_n = 0;
        #1;
        chk("ar count", count, 0);
        chk("ar iss0_valid", iss0_valid, 0);
        chk("ar iss0_payload", iss0_payload, 0);
        chk("ar cell_clear", cell_clear, 1);
        chk("ar ins_ready", ins_ready, 0);
        #3;
        clear_n = 1;
        @(posedge clk);
        #1;
        chk("ar release cell_clear", cell_clear, 0);
        chk("ar release count", count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
